lut_index_sequencer: RTL and testbench

- Iteration sequencer that sits directly upstream of lut_decoder in xfire_fpu_bkm.
- On a start request, steps the BKM iteration index n from 0 to N-1 and accepts one digit pair (d_x, d_y) per step from the digit-selection logic.
- Emits a registered, validated (n, digit) tuple that lut_decoder uses to look up the X_n/Y_n CSD constants.
- Provides start/busy/done handshake and a sticky illegal-digit flag.

---
 rtl/lut_index_sequencer.sv | 145 ++++++++++++++
 tb/tb_lut_index_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_index_sequencer.sv
// lut_index_sequencer: steps the BKM iteration index n from 0 to N-1 and
// forwards one registered, canonicalised (n, d_x, d_y) tuple per accepted
// digit pair to lut_decoder. It provides start/busy/done status and a
// sticky illegal-digit flag.
//
// Handshake: d_valid has no matching ready. In RUN, every enabled cycle
// with d_valid=1 is an accept. Outside RUN, and in any cycle with
// enable=0, d_valid is dropped. lut_valid qualifies lut_n/lut_dx/lut_dy for
// exactly the enabled cycles after an accept. Downstream logic cannot
// apply backpressure, so it must take the tuple in that cycle.
module lut_index_sequencer #(
  parameter int W  = 64,
  parameter int N  = 64,
  parameter int NW = 6
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          enable,
  input  logic          start,
  input  logic          d_valid,
  input  logic [1:0]    d_x,
  input  logic [1:0]    d_y,
  output logic [NW-1:0] lut_n,
  output logic [1:0]    lut_dx,
  output logic [1:0]    lut_dy,
  output logic          lut_valid,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    dbg_state
);

  // W is carried only to match the lut_decoder parameter set. Reject
  // configurations where the index register cannot hold N-1.
  if ((W < 1) || (NW < 1) || (N < 2) || (N > (1 << NW))) begin : g_bad_params
    $error("lut_index_sequencer: illegal W/N/NW combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [NW-1:0] LAST = NW'(N - 1);

  state_t        r_state;
  logic [NW-1:0] r_count;
  logic [NW-1:0] r_lut_n;
  logic [1:0]    r_lut_dx;
  logic [1:0]    r_lut_dy;
  logic          r_lut_valid;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic          w_illegal;

  // Code 10 is not a legal digit. It is forwarded as a zero digit so that
  // lut_decoder never sees it.
  function automatic logic [1:0] canon(input logic [1:0] d);
    return (d == 2'b10) ? 2'b00 : d;
  endfunction

  // Flag an illegal code on either digit. The flag is only used on accepts.
  always_comb begin
    w_illegal = (d_x == 2'b10) || (d_y == 2'b10);
  end

  // Sequencer FSM. Every output comes from a register. Clock-enable low
  // freezes all state, so a stall delays the sequence without dropping or
  // repeating an index.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_lut_n     <= '0;
      r_lut_dx    <= 2'b00;
      r_lut_dy    <= 2'b00;
      r_lut_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else if (enable) begin
      case (r_state)
        S_IDLE: begin
          r_lut_valid <= 1'b0;
          r_done      <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_count <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          r_lut_valid <= d_valid;
          if (d_valid) begin
            r_lut_n  <= r_count;
            r_lut_dx <= canon(d_x);
            r_lut_dy <= canon(d_y);
            if (w_illegal) begin
              r_err <= 1'b1;
            end
            // The last accept parks the count at N-1. It does not wrap.
            if (r_count == LAST) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_count <= r_count + NW'(1);
            end
          end
        end
        S_DONE: begin
          // This cycle shows the final tuple together with done.
          // A start request seen here is dropped on purpose.
          r_state     <= S_IDLE;
          r_lut_valid <= 1'b0;
          r_done      <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_lut_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  // While disabled, the tuple is not valid and done is not shown. Both come
  // back from the held registers once enable returns.
  always_comb begin
    lut_n     = r_lut_n;
    lut_dx    = r_lut_dx;
    lut_dy    = r_lut_dy;
    lut_valid = r_lut_valid & enable;
    busy      = r_busy;
    done      = r_done & enable;
    err       = r_err;
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_lut_index_sequencer.sv
// Directed testbench for lut_index_sequencer, configured with N=4.
// Each cycle vector holds the inputs for one clock cycle and the outputs
// expected during that same cycle, before the next rising edge.
module tb_lut_index_sequencer;

  localparam int W  = 64;
  localparam int N  = 4;
  localparam int NW = 3;
  localparam int OW = 1 + NW + 2 + 2 + 3;

  logic          clk;
  logic          srst;
  logic          enable;
  logic          start;
  logic          d_valid;
  logic [1:0]    d_x;
  logic [1:0]    d_y;
  logic [NW-1:0] lut_n;
  logic [1:0]    lut_dx;
  logic [1:0]    lut_dy;
  logic          lut_valid;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic          rst;
    logic          en;
    logic          st;
    logic          dv;
    logic [1:0]    dx;
    logic [1:0]    dy;
    logic          ck;   // compare this cycle
    logic          ct;   // also compare lut_n/lut_dx/lut_dy
    logic          v;
    logic [NW-1:0] n;
    logic [1:0]    ex;
    logic [1:0]    ey;
    logic          b;
    logic          d;
    logic          e;
  } vec_t;

  lut_index_sequencer #(.W(W), .N(N), .NW(NW)) dut (
    .clk       (clk),
    .srst      (srst),
    .enable    (enable),
    .start     (start),
    .d_valid   (d_valid),
    .d_x       (d_x),
    .d_y       (d_y),
    .lut_n     (lut_n),
    .lut_dx    (lut_dx),
    .lut_dy    (lut_dy),
    .lut_valid (lut_valid),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Clock and reset-time defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [OW-1:0] w_obs;
  assign w_obs = {lut_valid, lut_n, lut_dx, lut_dy, busy, done, err};

  function automatic vec_t mk(input logic rst, input logic en, input logic st, input logic dv,
                              input logic [1:0] dx, input logic [1:0] dy,
                              input logic ck, input logic ct, input logic v, input int n,
                              input logic [1:0] ex, input logic [1:0] ey,
                              input logic b, input logic d, input logic e);
    vec_t r;
    r.rst = rst; r.en = en; r.st = st; r.dv = dv; r.dx = dx; r.dy = dy;
    r.ck = ck; r.ct = ct; r.v = v; r.n = NW'(n); r.ex = ex; r.ey = ey;
    r.b = b; r.d = d; r.e = e;
    return r;
  endfunction

  function automatic logic [OW-1:0] exp_word(input vec_t x);
    return {x.v, x.n, x.ex, x.ey, x.b, x.d, x.e};
  endfunction

  function automatic logic [OW-1:0] mask_word(input vec_t x);
    return {1'b1, {NW{x.ct}}, {4{x.ct}}, 3'b111};
  endfunction

  // Driver: apply one cycle of inputs and let the outputs settle mid-cycle
  task automatic apply(input vec_t x);
    srst = x.rst; enable = x.en; start = x.st; d_valid = x.dv; d_x = x.dx; d_y = x.dy;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t q[$];
    logic [OW-1:0] m;
    q.push_back(mk(1,0,1,1,2'b10,2'b10, 0,0, 0,0,2'b00,2'b00, 0,0,0));
    q.push_back(mk(0,1,0,1,2'b10,2'b10, 1,1, 0,0,2'b00,2'b00, 0,0,0));
    q.push_back(mk(0,0,1,0,2'b00,2'b00, 1,1, 0,0,2'b00,2'b00, 0,0,0));
    q.push_back(mk(0,1,0,0,2'b00,2'b00, 1,1, 0,0,2'b00,2'b00, 0,0,0));
    foreach (q[i]) begin
      apply(q[i]);
      m = mask_word(q[i]);
      if (q[i].ck) begin
        checks++;
        if ((w_obs & m) !== (exp_word(q[i]) & m)) begin
          errors++;
          $display("FAIL reset cyc %0d: {v,n,dx,dy,busy,done,err} got %b want %b", i, w_obs & m, exp_word(q[i]) & m);
        end
      end
      tick();
    end
  endtask

  task automatic test_nominal();
    vec_t q[$];
    logic [OW-1:0] m;
    q.push_back(mk(1,1,0,0,2'b00,2'b00, 0,0, 0,0,2'b00,2'b00, 0,0,0));
    q.push_back(mk(0,1,1,0,2'b00,2'b00, 1,1, 0,0,2'b00,2'b00, 0,0,0));
    q.push_back(mk(0,1,0,1,2'b01,2'b11, 1,0, 0,0,2'b00,2'b00, 1,0,0));
    q.push_back(mk(0,1,0,1,2'b00,2'b01, 1,1, 1,0,2'b01,2'b11, 1,0,0));
    q.push_back(mk(0,1,0,1,2'b11,2'b00, 1,1, 1,1,2'b00,2'b01, 1,0,0));
    q.push_back(mk(0,1,0,1,2'b01,2'b01, 1,1, 1,2,2'b11,2'b00, 1,0,0));
    q.push_back(mk(0,1,0,0,2'b00,2'b00, 1,1, 1,3,2'b01,2'b01, 0,1,0));
    q.push_back(mk(0,1,0,0,2'b00,2'b00, 1,0, 0,0,2'b00,2'b00, 0,0,0));
    foreach (q[i]) begin
      apply(q[i]);
      m = mask_word(q[i]);
      if (q[i].ck) begin
        checks++;
        if ((w_obs & m) !== (exp_word(q[i]) & m)) begin
          errors++;
          $display("FAIL nominal cyc %0d: {v,n,dx,dy,busy,done,err} got %b want %b", i, w_obs & m, exp_word(q[i]) & m);
        end
      end
      tick();
    end
  endtask

  task automatic test_bubbles();
    vec_t q[$];
    logic [OW-1:0] m;
    q.push_back(mk(1,1,0,0,2'b00,2'b00, 0,0, 0,0,2'b00,2'b00, 0,0,0));
    q.push_back(mk(0,1,1,0,2'b00,2'b00, 1,0, 0,0,2'b00,2'b00, 0,0,0));
    q.push_back(mk(0,1,0,1,2'b01,2'b11, 1,0, 0,0,2'b00,2'b00, 1,0,0));
    q.push_back(mk(0,1,0,0,2'b10,2'b10, 1,1, 1,0,2'b01,2'b11, 1,0,0));
    q.push_back(mk(0,1,0,0,2'b10,2'b00, 1,0, 0,0,2'b00,2'b00, 1,0,0));
    q.push_back(mk(0,1,0,1,2'b00,2'b01, 1,0, 0,0,2'b00,2'b00, 1,0,0));
    q.push_back(mk(0,1,0,1,2'b11,2'b00, 1,1, 1,1,2'b00,2'b01, 1,0,0));
    q.push_back(mk(0,1,0,1,2'b01,2'b01, 1,1, 1,2,2'b11,2'b00, 1,0,0));
    q.push_back(mk(0,1,0,0,2'b00,2'b00, 1,1, 1,3,2'b01,2'b01, 0,1,0));
    q.push_back(mk(0,1,0,0,2'b00,2'b00, 1,0, 0,0,2'b00,2'b00, 0,0,0));
    foreach (q[i]) begin
      apply(q[i]);
      m = mask_word(q[i]);
      if (q[i].ck) begin
        checks++;
        if ((w_obs & m) !== (exp_word(q[i]) & m)) begin
          errors++;
          $display("FAIL bubbles cyc %0d: {v,n,dx,dy,busy,done,err} got %b want %b", i, w_obs & m, exp_word(q[i]) & m);
        end
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    vec_t q[$];
    logic [OW-1:0] m;
    q.push_back(mk(1,1,0,0,2'b00,2'b00, 0,0, 0,0,2'b00,2'b00, 0,0,0));
    q.push_back(mk(0,1,1,0,2'b00,2'b00, 1,0, 0,0,2'b00,2'b00, 0,0,0));
    q.push_back(mk(0,1,0,1,2'b01,2'b01, 1,0, 0,0,2'b00,2'b00, 1,0,0));
    q.push_back(mk(0,1,0,1,2'b10,2'b11, 1,1, 1,0,2'b01,2'b01, 1,0,0));
    q.push_back(mk(0,1,0,1,2'b01,2'b00, 1,1, 1,1,2'b00,2'b11, 1,0,1));
    q.push_back(mk(0,1,0,1,2'b11,2'b10, 1,1, 1,2,2'b01,2'b00, 1,0,1));
    q.push_back(mk(0,1,0,0,2'b00,2'b00, 1,1, 1,3,2'b11,2'b00, 0,1,1));
    q.push_back(mk(0,1,0,0,2'b00,2'b00, 1,0, 0,0,2'b00,2'b00, 0,0,1));
    q.push_back(mk(0,1,0,0,2'b00,2'b00, 1,0, 0,0,2'b00,2'b00, 0,0,1));
    q.push_back(mk(0,1,1,0,2'b00,2'b00, 1,0, 0,0,2'b00,2'b00, 0,0,1));
    q.push_back(mk(0,1,0,0,2'b00,2'b00, 1,0, 0,0,2'b00,2'b00, 1,0,0));
    foreach (q[i]) begin
      apply(q[i]);
      m = mask_word(q[i]);
      if (q[i].ck) begin
        checks++;
        if ((w_obs & m) !== (exp_word(q[i]) & m)) begin
          errors++;
          $display("FAIL illegal cyc %0d: {v,n,dx,dy,busy,done,err} got %b want %b", i, w_obs & m, exp_word(q[i]) & m);
        end
      end
      tick();
    end
  endtask

  task automatic test_enable_stall();
    vec_t q[$];
    logic [OW-1:0] m;
    q.push_back(mk(1,1,0,0,2'b00,2'b00, 0,0, 0,0,2'b00,2'b00, 0,0,0));
    q.push_back(mk(0,1,1,0,2'b00,2'b00, 1,0, 0,0,2'b00,2'b00, 0,0,0));
    q.push_back(mk(0,1,0,1,2'b01,2'b11, 1,0, 0,0,2'b00,2'b00, 1,0,0));
    q.push_back(mk(0,1,0,1,2'b00,2'b01, 1,1, 1,0,2'b01,2'b11, 1,0,0));
    q.push_back(mk(0,0,0,1,2'b11,2'b11, 1,1, 0,1,2'b00,2'b01, 1,0,0));
    q.push_back(mk(0,0,1,1,2'b11,2'b11, 1,1, 0,1,2'b00,2'b01, 1,0,0));
    q.push_back(mk(0,0,0,1,2'b11,2'b11, 1,1, 0,1,2'b00,2'b01, 1,0,0));
    q.push_back(mk(0,1,0,1,2'b11,2'b00, 1,1, 1,1,2'b00,2'b01, 1,0,0));
    q.push_back(mk(0,1,0,1,2'b01,2'b01, 1,1, 1,2,2'b11,2'b00, 1,0,0));
    q.push_back(mk(0,0,0,0,2'b00,2'b00, 1,1, 0,3,2'b01,2'b01, 0,0,0));
    q.push_back(mk(0,1,0,0,2'b00,2'b00, 1,1, 1,3,2'b01,2'b01, 0,1,0));
    q.push_back(mk(0,1,0,0,2'b00,2'b00, 1,0, 0,0,2'b00,2'b00, 0,0,0));
    foreach (q[i]) begin
      apply(q[i]);
      m = mask_word(q[i]);
      if (q[i].ck) begin
        checks++;
        if ((w_obs & m) !== (exp_word(q[i]) & m)) begin
          errors++;
          $display("FAIL enable_stall cyc %0d: {v,n,dx,dy,busy,done,err} got %b want %b", i, w_obs & m, exp_word(q[i]) & m);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    vec_t q[$];
    logic [OW-1:0] m;
    q.push_back(mk(1,1,0,0,2'b00,2'b00, 0,0, 0,0,2'b00,2'b00, 0,0,0));
    q.push_back(mk(0,1,1,0,2'b00,2'b00, 1,0, 0,0,2'b00,2'b00, 0,0,0));
    q.push_back(mk(0,1,0,1,2'b01,2'b11, 1,0, 0,0,2'b00,2'b00, 1,0,0));
    q.push_back(mk(0,1,0,1,2'b00,2'b10, 1,1, 1,0,2'b01,2'b11, 1,0,0));
    q.push_back(mk(1,1,0,1,2'b11,2'b11, 1,1, 1,1,2'b00,2'b00, 1,0,1));
    q.push_back(mk(0,1,0,1,2'b11,2'b11, 1,1, 0,0,2'b00,2'b00, 0,0,0));
    q.push_back(mk(0,1,0,0,2'b00,2'b00, 1,1, 0,0,2'b00,2'b00, 0,0,0));
    q.push_back(mk(0,1,1,0,2'b00,2'b00, 1,1, 0,0,2'b00,2'b00, 0,0,0));
    q.push_back(mk(0,1,0,1,2'b11,2'b01, 1,0, 0,0,2'b00,2'b00, 1,0,0));
    q.push_back(mk(0,1,0,1,2'b01,2'b00, 1,1, 1,0,2'b11,2'b01, 1,0,0));
    q.push_back(mk(0,1,0,1,2'b00,2'b00, 1,1, 1,1,2'b01,2'b00, 1,0,0));
    q.push_back(mk(0,1,0,1,2'b01,2'b11, 1,1, 1,2,2'b00,2'b00, 1,0,0));
    q.push_back(mk(0,1,0,0,2'b00,2'b00, 1,1, 1,3,2'b01,2'b11, 0,1,0));
    q.push_back(mk(0,1,0,0,2'b00,2'b00, 1,0, 0,0,2'b00,2'b00, 0,0,0));
    foreach (q[i]) begin
      apply(q[i]);
      m = mask_word(q[i]);
      if (q[i].ck) begin
        checks++;
        if ((w_obs & m) !== (exp_word(q[i]) & m)) begin
          errors++;
          $display("FAIL reset_mid cyc %0d: {v,n,dx,dy,busy,done,err} got %b want %b", i, w_obs & m, exp_word(q[i]) & m);
        end
      end
      tick();
    end
  endtask

  task automatic test_start_while_busy();
    vec_t q[$];
    logic [OW-1:0] m;
    q.push_back(mk(1,1,0,0,2'b00,2'b00, 0,0, 0,0,2'b00,2'b00, 0,0,0));
    q.push_back(mk(0,1,1,0,2'b00,2'b00, 1,0, 0,0,2'b00,2'b00, 0,0,0));
    q.push_back(mk(0,1,1,1,2'b01,2'b01, 1,0, 0,0,2'b00,2'b00, 1,0,0));
    q.push_back(mk(0,1,1,1,2'b11,2'b11, 1,1, 1,0,2'b01,2'b01, 1,0,0));
    q.push_back(mk(0,1,1,0,2'b00,2'b00, 1,1, 1,1,2'b11,2'b11, 1,0,0));
    q.push_back(mk(0,1,0,1,2'b00,2'b00, 1,0, 0,0,2'b00,2'b00, 1,0,0));
    q.push_back(mk(0,1,1,1,2'b01,2'b11, 1,1, 1,2,2'b00,2'b00, 1,0,0));
    q.push_back(mk(0,1,1,1,2'b11,2'b11, 1,1, 1,3,2'b01,2'b11, 0,1,0));
    q.push_back(mk(0,1,0,1,2'b11,2'b11, 1,0, 0,0,2'b00,2'b00, 0,0,0));
    q.push_back(mk(0,1,0,0,2'b00,2'b00, 1,0, 0,0,2'b00,2'b00, 0,0,0));
    foreach (q[i]) begin
      apply(q[i]);
      m = mask_word(q[i]);
      if (q[i].ck) begin
        checks++;
        if ((w_obs & m) !== (exp_word(q[i]) & m)) begin
          errors++;
          $display("FAIL start_while_busy cyc %0d: {v,n,dx,dy,busy,done,err} got %b want %b", i, w_obs & m, exp_word(q[i]) & m);
        end
      end
      tick();
    end
  endtask

  // Test sequence and final report
  initial begin
    srst = 1'b1; enable = 1'b0; start = 1'b0; d_valid = 1'b0; d_x = 2'b00; d_y = 2'b00;
    test_reset();
    test_nominal();
    test_bubbles();
    test_illegal();
    test_enable_stall();
    test_reset_mid();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
